// File: rtl/xga_video_timing_gen_if.sv
// Raster timing bundle between the timing generator (master) and the
// background renderers (slave).
interface xga_video_timing_gen_if;
  logic        pix_ce;
  logic [10:0] pix_x;
  logic [10:0] pix_y;
  logic        video_active;
  logic        hsync;
  logic        vsync;
  logic        line_start;
  logic        frame_start;
  logic [9:0]  frame_count;

  modport master (
    input  pix_ce,
    output pix_x, pix_y, video_active, hsync, vsync,
           line_start, frame_start, frame_count
  );

  modport slave (
    output pix_ce,
    input  pix_x, pix_y, video_active, hsync, vsync,
           line_start, frame_start, frame_count
  );
endinterface

// File: rtl/xga_video_timing_gen.sv
// Raster timing generator: h/v counters with every output registered from the
// decoded next position, so syncs are glitch-free and aligned with pix_x/pix_y.
module xga_video_timing_gen #(
  parameter int H_ACTIVE  = 1024,
  parameter int H_FP      = 24,
  parameter int H_SYNC    = 136,
  parameter int H_BP      = 160,
  parameter int V_ACTIVE  = 768,
  parameter int V_FP      = 3,
  parameter int V_SYNC    = 6,
  parameter int V_BP      = 29,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  xga_video_timing_gen_if.master        bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS      = 11'(H_ACTIVE);
  localparam logic [10:0] V_VIS      = 11'(V_ACTIVE);
  localparam logic [10:0] HS_START   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_START   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END     = 11'(V_ACTIVE + V_FP + V_SYNC);

  if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_size_check
    $error("xga_video_timing_gen: H_TOTAL/V_TOTAL exceed 11-bit counter range");
  end

  logic [10:0] h, v;
  logic [10:0] h_nxt, v_nxt;
  logic        h_wrap, v_wrap;
  logic        video_active_q, hsync_q, vsync_q;
  logic        line_start_q, frame_start_q;
  logic [9:0]  frame_count_q;

  assign h_wrap = (h == H_LAST);
  assign v_wrap = (v == V_LAST);

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    h_nxt = h_wrap ? '0 : h + 11'd1;
    v_nxt = v;
    if (h_wrap) v_nxt = v_wrap ? '0 : v + 11'd1;
  end

  // Reset parks the raster on the last pixel so the first advance lands on (0,0)
  // and counts as the start of frame 1.
  // NOTE: sequential state uses non-blocking assignments so all flops update
  // from the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h              <= H_LAST;
      v              <= V_LAST;
      video_active_q <= 1'b0;
      hsync_q        <= ~HSYNC_POL;
      vsync_q        <= ~VSYNC_POL;
      line_start_q   <= 1'b0;
      frame_start_q  <= 1'b0;
      frame_count_q  <= '0;
    end else if (bus.pix_ce) begin
      h              <= h_nxt;
      v              <= v_nxt;
      video_active_q <= (h_nxt < H_VIS) && (v_nxt < V_VIS);
      hsync_q        <= (h_nxt >= HS_START && h_nxt < HS_END) ? HSYNC_POL : ~HSYNC_POL;
      vsync_q        <= (v_nxt >= VS_START && v_nxt < VS_END) ? VSYNC_POL : ~VSYNC_POL;
      line_start_q   <= h_wrap;
      frame_start_q  <= h_wrap && v_wrap;
      if (h_wrap && v_wrap) frame_count_q <= frame_count_q + 10'd1;
    end else begin
      line_start_q   <= 1'b0;
      frame_start_q  <= 1'b0;
    end
  end

  assign bus.pix_x        = h;
  assign bus.pix_y        = v;
  assign bus.video_active = video_active_q;
  assign bus.hsync        = hsync_q;
  assign bus.vsync        = vsync_q;
  assign bus.line_start   = line_start_q;
  assign bus.frame_start  = frame_start_q;
  assign bus.frame_count  = frame_count_q;

endmodule

// File: tb/tb_xga_video_timing_gen.sv
// Scoreboard bench for xga_video_timing_gen on a small raster: a position-based
// reference model queues expected outputs, a monitor compares each clock.
module tb_xga_video_timing_gen;

  localparam int HA = 3, HFP = 1, HS = 2, HBP = 1;
  localparam int VA = 2, VFP = 1, VS = 1, VBP = 1;
  localparam bit HPOL = 1'b0, VPOL = 1'b1;
  localparam int HT = HA + HFP + HS + HBP;   // 7
  localparam int VT = VA + VFP + VS + VBP;   // 5
  localparam int FT = HT * VT;               // 35 pixels per frame
  localparam int CYCLE_BUDGET = 60000;

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic        va;
    logic        hs;
    logic        vs;
    logic        ls;
    logic        fs;
    logic [9:0]  fc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  xga_video_timing_gen_if bus ();

  xga_video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .HSYNC_POL(HPOL), .VSYNC_POL(VPOL)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.master)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];

  // Reference model: linear position within the frame plus a frame tally.
  int pos;
  int fc_model;
  int frames_done;
  int wraps_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model_view(input int p, input bit ls, input bit fs, input int fc);
    exp_t e;
    int h, v;
    h = p % HT;
    v = p / HT;
    e.x  = 11'(h);
    e.y  = 11'(v);
    e.va = (h < HA) && (v < VA);
    e.hs = (h >= HA + HFP && h < HA + HFP + HS) ? HPOL : ~HPOL;
    e.vs = (v >= VA + VFP && v < VA + VFP + VS) ? VPOL : ~VPOL;
    e.ls = ls;
    e.fs = fs;
    e.fc = 10'(fc);
    return e;
  endfunction

  task automatic compare(input string tag, input exp_t e);
    check({tag, ".pix_x"},        32'(bus.pix_x),        32'(e.x));
    check({tag, ".pix_y"},        32'(bus.pix_y),        32'(e.y));
    check({tag, ".video_active"}, 32'(bus.video_active), 32'(e.va));
    check({tag, ".hsync"},        32'(bus.hsync),        32'(e.hs));
    check({tag, ".vsync"},        32'(bus.vsync),        32'(e.vs));
    check({tag, ".line_start"},   32'(bus.line_start),   32'(e.ls));
    check({tag, ".frame_start"},  32'(bus.frame_start),  32'(e.fs));
    check({tag, ".frame_count"},  32'(bus.frame_count),  32'(e.fc));
  endtask

  task automatic model_reset();
    pos      = FT - 1;
    fc_model = 0;
  endtask

  // One stimulus cycle: drive pix_ce, advance the model, queue the expectation.
  task automatic step(input bit force_ce);
    bit ce;
    bit ls, fs;
    ce = force_ce || ($urandom_range(7, 0) != 0);
    bus.pix_ce = ce;
    ls = 1'b0;
    fs = 1'b0;
    if (ce) begin
      pos = (pos + 1) % FT;
      ls  = (pos % HT) == 0;
      fs  = (pos == 0);
      if (fs) begin
        fc_model = (fc_model + 1) % 1024;
        frames_done++;
      end
    end
    exp_q.push_back(model_view(pos, ls, fs, fc_model));
    @(negedge clk);
  endtask

  exp_t mon_e;
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      compare("cyc", mon_e);
      if (bus.frame_start === 1'b1 && bus.frame_count === 10'd0) wraps_seen++;
    end
  end

  initial begin
    int cyc;
    exp_t rst_e;
    rst_e = model_view(FT - 1, 1'b0, 1'b0, 0);
    rst_e.va = 1'b0;
    rst_e.hs = ~HPOL;
    rst_e.vs = ~VPOL;

    rst_n      = 1'b0;
    bus.pix_ce = 1'b0;
    frames_done = 0;
    model_reset();
    repeat (3) @(negedge clk);
    compare("por", rst_e);

    // Reset must dominate an asserted pixel enable.
    bus.pix_ce = 1'b1;
    @(posedge clk);
    #1 compare("por_ce", rst_e);

    @(negedge clk);
    bus.pix_ce = 1'b0;
    rst_n = 1'b1;
    model_reset();
    step(1'b1);
    // Explicit 1,0,0,1 hold pattern, then random enables.
    bus.pix_ce = 1'b0;
    exp_q.push_back(model_view(pos, 1'b0, 1'b0, fc_model));
    @(negedge clk);
    exp_q.push_back(model_view(pos, 1'b0, 1'b0, fc_model));
    @(negedge clk);
    step(1'b1);
    repeat (150) step(1'b0);

    // Asynchronous reset mid-frame, between clock edges.
    bus.pix_ce = 1'b0;
    #2 rst_n = 1'b0;
    #1 compare("mid_rst", rst_e);
    check("mid_rst.queue_empty", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    frames_done = 0;
    step(1'b1);

    cyc = 0;
    while (frames_done < 1026 && cyc < CYCLE_BUDGET) begin
      step(1'b0);
      cyc++;
    end
    check("run.within_budget", 32'(cyc < CYCLE_BUDGET), 32'd1);

    bus.pix_ce = 1'b0;
    @(negedge clk);
    check("end.queue_drained", 32'(exp_q.size()), 32'd0);
    check("end.frame_count_wrapped", 32'(wraps_seen >= 1), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
